alu_mcycle: RTL and testbench

// - Parametrised multi-cycle math ALU: MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU, SLL/SRL/SRA.
// - Sits between the issuer and the commiter, alongside the single-cycle ALUs.
// - Adds over the previous generation:
//   - XLEN and per-cycle step widths are parameters.
//   - Ready/valid issue handshake, with back-to-back accept on the clear cycle.
//   - Flush (abort mid-operation).
//   - RISC-V divide corner-case fast paths.

---
 rtl/core_config_pkg.sv | 47 ++++
 rtl/alu_mcycle_div_iter.sv | 62 ++++++
 rtl/alu_mcycle.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_mcycle.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// Shared core configuration: ALU command encodings, multi-cycle ALU state type
// and sizing helpers used by the multi-cycle math ALU.
package core_config_pkg;

  typedef enum logic [4:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_AND    = 5'd3,
    ALU_OR     = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SLT    = 5'd6,
    ALU_SLTU   = 5'd7,
    ALU_SLL    = 5'd8,
    ALU_SRL    = 5'd9,
    ALU_SRA    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_commands_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } alu_mc_state_t;

  // Iteration counter must hold XLEN itself (the divider's full count).
  function automatic int mc_cnt_width(input int xlen);
    return $clog2(xlen + 1);
  endfunction

  function automatic logic is_mc_cmd(input alu_commands_t c);
    case (c)
      ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mcycle_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per step.
// quotient/remainder show the values produced by the step taken this cycle.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN:0]   trial, diff;
  logic [XLEN-1:0] rem_n, quo_n;

  // Dividend bits shift out of the top of quo_q while quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_n = diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = rem_n;
      quo_d = quo_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_n;
  assign remainder = rem_n;

endmodule

// File: rtl/alu_mcycle.sv
// Multi-cycle math ALU: stepped multiply, restoring divide, stepped shifts.
// Handshake: an op is accepted on a cycle with in_valid & in_ready & supported cmd & !flush.
module alu_mcycle
  import core_config_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_STEP   = 4,
  parameter int SHIFT_STEP = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       arg0,
  input  logic [XLEN-1:0]       arg1,
  input  alu_commands_t         cmd,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  i_error,
  output logic                  busy,
  output logic [XLEN-1:0]       res,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  valid,
  output logic                  o_error,
  input  logic                  clear,
  input  logic                  flush,
  output alu_mc_state_t         dbg_state
);

  localparam int CNT_W = mc_cnt_width(XLEN);
  localparam int SH_W  = $clog2(XLEN);
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  STEP_MAX  = XLEN'(SHIFT_STEP);

  alu_mc_state_t         state_q, state_d;
  alu_commands_t         cmd_q, cmd_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [2*XLEN-1:0]     a_q, a_d, acc_q, acc_d;
  logic [XLEN-1:0]       b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q, neg_d, rneg_q, rneg_d, err_q, err_d;

  logic supported, accept;
  logic in_mul, in_div, in_rem, in_sgn0, in_sgn1, run_mul, run_div, run_rem;
  logic a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, div_quo, div_rem, q_fix, r_fix;
  logic [XLEN-1:0] sh_amt, sh_left, sh_data, fin_res;
  logic [SH_W-1:0] shamt;
  logic [2*XLEN-1:0] acc_n, prod;
  logic div_start, div_step, last;

  assign supported = is_mc_cmd(cmd);
  assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & clear & !flush);
  assign accept    = in_valid & in_ready & supported & !flush;
  assign i_error   = in_valid & in_ready & !supported;
  assign busy      = !in_ready;

  // Operand decode for the incoming op; divider and multiplier work on magnitudes.
  always_comb begin
    in_mul  = cmd inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    in_div  = cmd inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    in_rem  = cmd inside {ALU_REM, ALU_REMU};
    in_sgn0 = cmd inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    in_sgn1 = cmd inside {ALU_MULH, ALU_DIV, ALU_REM};
    run_mul = cmd_q inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    run_div = cmd_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    run_rem = cmd_q inside {ALU_REM, ALU_REMU};
    a_neg   = in_sgn0 & arg0[XLEN-1];
    b_neg   = in_sgn1 & arg1[XLEN-1];
    a_abs   = a_neg ? -arg0 : arg0;
    b_abs   = b_neg ? -arg1 : arg1;
    shamt   = arg1[SH_W-1:0];
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    res_d     = res_q;
    err_d     = err_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    last      = 1'b0;
    acc_n     = acc_q;
    prod      = '0;
    q_fix     = '0;
    r_fix     = '0;
    sh_amt    = '0;
    sh_left   = '0;
    sh_data   = '0;
    fin_res   = '0;

    case (state_q)
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (run_mul) begin
          for (int i = 0; i < MUL_STEP; i++) begin
            if (b_q[i]) acc_n = acc_n + (a_q << i);
          end
          acc_d   = acc_n;
          a_d     = a_q << MUL_STEP;
          b_d     = b_q >> MUL_STEP;
          prod    = neg_q ? -acc_n : acc_n;
          fin_res = (cmd_q == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          last    = (cnt_q == CNT_W'(1));
        end else if (run_div) begin
          div_step = !flush;
          q_fix    = neg_q ? -div_quo : div_quo;
          r_fix    = rneg_q ? -div_rem : div_rem;
          fin_res  = run_rem ? r_fix : q_fix;
          last     = (cnt_q == CNT_W'(1));
        end else begin
          // b_q holds the shift distance still to apply.
          sh_amt  = (b_q < STEP_MAX) ? b_q : STEP_MAX;
          sh_left = b_q - sh_amt;
          case (cmd_q)
            ALU_SLL: sh_data = a_q[XLEN-1:0] << sh_amt;
            ALU_SRA: sh_data = $signed(a_q[XLEN-1:0]) >>> sh_amt;
            default: sh_data = a_q[XLEN-1:0] >> sh_amt;
          endcase
          a_d     = {{XLEN{1'b0}}, sh_data};
          b_d     = sh_left;
          fin_res = sh_data;
          last    = (sh_left == '0);
        end
        if (last) begin
          res_d   = fin_res;
          err_d   = 1'b0;
          state_d = OUT;
        end
      end
      OUT: if (clear) state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      cmd_d   = cmd;
      rd_d    = i_rd;
      err_d   = 1'b0;
      neg_d   = a_neg ^ b_neg;
      rneg_d  = a_neg;
      acc_d   = '0;
      state_d = RUN;
      if (in_mul) begin
        a_d   = {{XLEN{1'b0}}, a_abs};
        b_d   = b_abs;
        cnt_d = MUL_ITERS;
      end else if (in_div) begin
        if (arg1 == '0) begin
          res_d   = in_rem ? arg0 : '1;
          err_d   = 1'b1;
          state_d = OUT;
        end else if (in_sgn0 && arg0 == MIN_INT && arg1 == '1) begin
          res_d   = in_rem ? '0 : arg0;
          state_d = OUT;
        end else begin
          div_start = 1'b1;
          cnt_d     = DIV_ITERS;
        end
      end else if (shamt == '0) begin
        res_d   = arg0;
        state_d = OUT;
      end else begin
        a_d = {{XLEN{1'b0}}, arg0};
        b_d = XLEN'(shamt);
      end
    end

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= ALU_NOP;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign valid     = (state_q == OUT);
  assign res       = valid ? res_q : '0;
  assign o_rd      = valid ? rd_q : '0;
  assign o_error   = valid & err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mcycle.sv
// Self-checking bench for alu_mcycle (XLEN=32, MUL_STEP=4, SHIFT_STEP=8).
module tb_alu_mcycle;
  import core_config_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, i_error, busy, valid, o_error, clear, flush;
  logic [31:0]   arg0, arg1, res;
  logic [4:0]    i_rd, o_rd;
  alu_commands_t cmd;
  alu_mc_state_t dbg_state;

  logic [37:0] exp_q[$];
  int          lat_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  alu_mcycle #(.XLEN(32), .REG_ADDR_W(5), .MUL_STEP(4), .SHIFT_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .arg0(arg0), .arg1(arg1), .cmd(cmd), .i_rd(i_rd), .i_error(i_error),
    .busy(busy), .res(res), .o_rd(o_rd), .valid(valid), .o_error(o_error),
    .clear(clear), .flush(flush), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: exact 64-bit products, SV integer division, native shifts.
  function automatic void model(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    logic [63:0] ea, eb, p;
    int          sa, sb;
    logic [4:0]  sh;
    logic        sgn, remop;
    r = '0; e = 1'b0; lat = 1;
    case (c)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: begin
        ea  = (c == ALU_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
        eb  = (c == ALU_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        r   = (c == ALU_MUL) ? p[31:0] : p[63:32];
        lat = 9;
      end
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        sgn   = (c == ALU_DIV) || (c == ALU_REM);
        remop = (c == ALU_REM) || (c == ALU_REMU);
        if (b == 32'h0) begin
          r = remop ? a : 32'hFFFF_FFFF;
          e = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = remop ? 32'h0 : a;
        end else begin
          lat = 33;
          if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            r  = remop ? 32'(sa % sb) : 32'(sa / sb);
          end else begin
            r = remop ? (a % b) : (a / b);
          end
        end
      end
      default: begin
        sh = b[4:0];
        if (c == ALU_SLL)      r = a << sh;
        else if (c == ALU_SRL) r = a >> sh;
        else                   r = $signed(a) >>> sh;
        lat = (sh == 0) ? 1 : (int'(sh) + 7) / 8 + 1;
      end
    endcase
  endfunction

  // driver: present one op at a negedge, optionally with clear, hold through one edge
  task automatic drive(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic with_clear);
    @(negedge clk);
    cmd = c; arg0 = a; arg1 = b; i_rd = rd; in_valid = 1'b1; clear = with_clear;
    #1 check("in_ready_at_issue", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic push_exp(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    logic [31:0] r;
    logic        e;
    int          lat;
    model(c, a, b, r, e, lat);
    exp_q.push_back({e, rd, r});
    lat_q.push_back(lat);
  endtask

  // scoreboard side: wait for valid (bounded), pop and compare
  task automatic collect(input logic do_clear);
    int          lat;
    logic [37:0] exp;
    int          exp_lat;
    lat = 1;
    @(negedge clk);
    while (!valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    exp     = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    if (!valid) begin
      check("valid_timeout", 0, 1);
    end else begin
      check("res", res, exp[31:0]);
      check("o_rd", o_rd, exp[36:32]);
      check("o_error", o_error, exp[37]);
      check("latency", lat, exp_lat);
      check("busy_in_out", busy, 1);
      if (do_clear) begin
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
      end
    end
  endtask

  task automatic run_op(input alu_commands_t c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    push_exp(c, a, b, rd);
    drive(c, a, b, rd, 1'b0);
    collect(1'b1);
  endtask

  alu_commands_t ops[11] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
                             ALU_REM, ALU_REMU, ALU_SLL, ALU_SRL, ALU_SRA};

  initial begin
    int          vcnt;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; flush = 1'b0;
    arg0 = '0; arg1 = '0; cmd = ALU_NOP; i_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_res", res, 0);
    check("rst_o_rd", o_rd, 0);
    check("rst_o_error", o_error, 0);
    rst_n = 1'b1;

    run_op(ALU_MUL,   32'hFFFF_FFFF, 32'h2, 5'd1);
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'h2, 5'd2);
    run_op(ALU_MULH,  32'hFFFF_FFFF, 32'h2, 5'd3);
    run_op(ALU_DIV,   32'hFFFF_FFF9, 32'h2, 5'd4);
    run_op(ALU_REM,   32'hFFFF_FFF9, 32'h2, 5'd5);
    run_op(ALU_DIVU,  32'h5,         32'h0, 5'd6);
    run_op(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    run_op(ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op(ALU_SRA,   32'h8000_0000, 32'd31, 5'd9);
    run_op(ALU_SLL,   32'h1234,      32'd0,  5'd10);
    run_op(ALU_SRL,   32'hF000_0000, 32'd36, 5'd11);

    // flush in RUN cycle 10 of a DIV
    drive(ALU_DIV, 32'd100, 32'd7, 5'd12, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_pre_state", dbg_state, RUN);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_state", dbg_state, IDLE);
    check("flush_in_ready", in_ready, 1);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("flush_no_valid", vcnt, 0);
    run_op(ALU_MUL, 32'd3, 32'd5, 5'd13);

    // back-to-back accept on the clear cycle
    push_exp(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14);
    drive(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b0);
    collect(1'b0);
    push_exp(ALU_SLL, 32'd1, 32'd1, 5'd15);
    drive(ALU_SLL, 32'd1, 32'd1, 5'd15, 1'b1);
    collect(1'b1);

    // unsupported command
    @(negedge clk);
    cmd = ALU_ADD; arg0 = 32'd1; arg1 = 32'd2; in_valid = 1'b1;
    #1 check("unsup_i_error", i_error, 1);
    check("unsup_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("unsup_state", dbg_state, IDLE);
    check("unsup_valid", valid, 0);

    // asynchronous reset mid-MUL
    drive(ALU_MUL, 32'd7, 32'd9, 5'd16, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_mul_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_state", dbg_state, IDLE);
    check("arst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17);

    // random traffic
    for (int n = 0; n < 30; n++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 40));
      run_op(ops[$urandom_range(0, 10)], ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
